i2c_master_engine: RTL and testbench

//  Single-byte I2C bus master feeding the master-side SCL/SDL pins of the translator.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_clk_gen.sv | 38 +++
 rtl/i2c_master_engine.sv | 149 ++++++++++++++
 tb/tb_i2c_master_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C FSM state codes, framing constants and line-drive helper
package i2c_pkg;

    localparam int I2C_QUARTERS = 4;
    localparam int I2C_BITS     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_ACK1  = 3'd3,
        ST_DATA  = 3'd4,
        ST_ACK2  = 3'd5,
        ST_STOP  = 3'd6,
        ST_SDATA = 3'd7
    } i2c_state_e;

    // {scl_oe, sdl_oe} for a given state and quarter; b is the bit being transmitted
    function automatic logic [1:0] line_drive(input i2c_state_e st, input logic [1:0] q, input logic b);
        logic [1:0] r;
        r = 2'b00;
        case (st)
            ST_START:                   r = {1'b0, q[1]};
            ST_ADDR, ST_DATA:           r = {~q[1], ~b};
            ST_ACK1, ST_ACK2, ST_SDATA: r = {~q[1], 1'b0};
            ST_STOP:                    r = {q == 2'd0, ~q[1]};
            default:                    r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// rtl/i2c_clk_gen.sv - DIV prescaler producing a quarter-period tick and 2-bit quarter index
module i2c_clk_gen #(
    parameter int DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hold,
    output logic       qtick,
    output logic [1:0] quarter
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [1:0]    quarter_q;

    assign qtick   = en && !hold && (cnt_q == CW'(DIV - 1));
    assign quarter = quarter_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            quarter_q <= 2'd0;
        end else if (!en) begin
            cnt_q     <= '0;
            quarter_q <= 2'd0;
        end else if (!hold) begin
            if (qtick) begin
                cnt_q     <= '0;
                quarter_q <= quarter_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_master_engine.sv
// rtl/i2c_master_engine.sv - single-byte I2C master; I2C_CLK_STRETCH_EN enables slave clock stretching
module i2c_master_engine
    import i2c_pkg::*;
#(
    parameter int DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sdl_oe,
    input  logic       scl_in,
    input  logic       sdl_in
);

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q;
    logic [7:0] rx_q;
    logic       nack_q;
    logic       fin_q;
    logic       cmd_ready_q, busy_q;
    logic       rsp_valid_q, rsp_nack_q;
    logic [7:0] rsp_rdata_q;
    logic       scl_oe_q, sdl_oe_q;

    logic       qtick, hold, last_q, last_bit, tx_bit;
    logic [1:0] quarter, quarter_d;
    logic [7:0] tx_byte;

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds SCL low after we released it: freeze the quarter timer
    assign hold = quarter[1] && !scl_oe_q && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    i2c_clk_gen #(.DIV(DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q != ST_IDLE),
        .hold    (hold),
        .qtick   (qtick),
        .quarter (quarter)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        last_q    = (quarter == 2'(I2C_QUARTERS - 1));
        last_bit  = (bit_cnt_q == 3'(I2C_BITS - 1));
        if (last_q) begin
            case (state_q)
                ST_START: begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = 3'd0;
                end
                ST_ADDR: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) state_d = ST_ACK1;
                end
                ST_ACK1:  state_d = nack_q ? ST_STOP : (rw_q ? ST_SDATA : ST_DATA);
                ST_DATA, ST_SDATA: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) state_d = ST_ACK2;
                end
                ST_ACK2:  state_d = ST_STOP;
                ST_STOP:  state_d = ST_IDLE;
                default:  state_d = state_q;
            endcase
        end
        quarter_d = quarter + 2'd1;
        tx_byte   = (state_d == ST_ADDR) ? {addr_q, rw_q} : wdata_q;
        tx_bit    = tx_byte[3'd7 - bit_cnt_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            addr_q      <= 7'd0;
            rw_q        <= 1'b0;
            wdata_q     <= 8'd0;
            rx_q        <= 8'd0;
            nack_q      <= 1'b0;
            fin_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_nack_q  <= 1'b0;
            scl_oe_q    <= 1'b0;
            sdl_oe_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (fin_q) begin
                    fin_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_nack_q  <= nack_q;
                    rsp_rdata_q <= rw_q ? rx_q : 8'd0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end else if (cmd_valid && cmd_ready_q) begin
                    addr_q      <= cmd_addr;
                    rw_q        <= cmd_rw;
                    wdata_q     <= cmd_wdata;
                    rx_q        <= 8'd0;
                    nack_q      <= 1'b0;
                    bit_cnt_q   <= 3'd0;
                    state_q     <= ST_START;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
            end else if (qtick) begin
                // SDL is sampled at the q2->q3 boundary, mid SCL-high
                if (quarter == 2'd2) begin
                    if (state_q == ST_ACK1 || (state_q == ST_ACK2 && !rw_q)) nack_q <= nack_q | sdl_in;
                    if (state_q == ST_SDATA) rx_q <= {rx_q[6:0], sdl_in};
                end
                if (state_q == ST_STOP && last_q) fin_q <= 1'b1;
                state_q               <= state_d;
                bit_cnt_q             <= bit_cnt_d;
                {scl_oe_q, sdl_oe_q}  <= line_drive(state_d, quarter_d, tx_bit);
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;
    assign scl_oe    = scl_oe_q;
    assign sdl_oe    = sdl_oe_q;

endmodule

// File: tb/tb_i2c_master_engine.sv
// tb/tb_i2c_master_engine.sv - self-checking bench for i2c_master_engine against a quarter-level bus model
module tb_i2c_master_engine;

    localparam int DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
    localparam bit STRETCH_ON = 1'b1;
`else
    localparam bit STRETCH_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_nack, busy;
    logic [7:0] rsp_rdata;
    logic       scl_oe, sdl_oe, scl_in, sdl_in;
    logic       slave_pull = 1'b0;
    logic       scl_hold   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    assign scl_in = ~scl_oe & ~scl_hold;
    assign sdl_in = ~sdl_oe & ~slave_pull;

    always #5 clk = ~clk;

    i2c_master_engine #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sdl_oe    (sdl_oe),
        .scl_in    (scl_in),
        .sdl_in    (sdl_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected {scl_oe, sdl_oe} in quarter k of a transaction, laid out as
    // START(0-3) ADDR(4-35) ACK1(36-39) DATA(40-71) ACK2(72-75) STOP(76-79)
    function automatic logic [1:0] model_lines(input int k, input logic [7:0] abyte, input logic rw,
                                               input logic [7:0] wd, input bit addr_nack);
        int q;
        int kk;
        q  = k % 4;
        kk = k;
        if (kk < 4)  return {1'b0, q >= 2};
        if (kk < 36) return {q < 2, ~abyte[7 - (kk - 4) / 4]};
        if (kk < 40) return {q < 2, 1'b0};
        if (addr_nack) kk = kk + 36;
        if (kk < 72) return rw ? {q < 2, 1'b0} : {q < 2, ~wd[7 - (kk - 40) / 4]};
        if (kk < 76) return {q < 2, 1'b0};
        return {q == 0, q < 2};
    endfunction

    function automatic logic model_pull(input int k, input logic rw, input bit ack1, input bit ack2,
                                        input logic [7:0] rd);
        if (k >= 36 && k < 40) return ack1;
        if (!ack1) return 1'b0;
        if (rw && k >= 40 && k < 72) return ~rd[7 - (k - 40) / 4];
        if (!rw && k >= 72 && k < 76) return ack2;
        return 1'b0;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic [6:0] addr, input logic rw, input logic [7:0] wd,
                           input bit ack1, input bit ack2, input logic [7:0] rd,
                           input bit stretch, input bit hold_valid, input int abort_at);
        int nq, exp_lat, c, k, eff, rsp_at, rsp_cnt;
        bit aborted;
        logic [7:0] abyte;
        logic       exp_nack;
        logic [7:0] exp_rdata;
        abyte     = {addr, rw};
        nq        = ack1 ? 80 : 44;
        exp_lat   = nq * DIV + 1 + ((stretch && STRETCH_ON) ? 20 : 0);
        exp_nack  = !ack1 || (!rw && !ack2);
        exp_rdata = (rw && ack1) ? rd : 8'd0;
        aborted   = 1'b0;
        rsp_at    = -1;
        rsp_cnt   = 0;

        @(negedge clk);
        check($sformatf("%s:ready_before", tag), 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_rw    = rw;
        cmd_wdata = wd;
        @(posedge clk);
        #1;
        cmd_addr  = ~addr;
        cmd_wdata = ~wd;
        if (!hold_valid) cmd_valid = 1'b0;
        c = 0;

        while (c < exp_lat + 40) begin
            @(posedge clk);
            c++;
            #1;
            eff = c;
            if (stretch && STRETCH_ON) eff = (c < 72) ? c : ((c < 92) ? 72 : c - 20);
            scl_hold   = stretch && (c >= 72) && (c < 92);
            k          = eff / DIV;
            slave_pull = (!aborted && k < nq) ? model_pull(k, rw, ack1, ack2, rd) : 1'b0;
            @(negedge clk);
            if (c == 1) begin
                check($sformatf("%s:busy_after_accept", tag), 32'(busy), 1);
                check($sformatf("%s:ready_after_accept", tag), 32'(cmd_ready), 0);
            end
            if (!aborted && k < nq && (eff % DIV) == DIV / 2)
                check($sformatf("%s:lines_q%0d", tag, k), 32'({scl_oe, sdl_oe}),
                      32'(model_lines(k, abyte, rw, wd, !ack1)));
            if (c == abort_at) begin
                #1 rst = 1'b1;
                #1;
                check($sformatf("%s:rst_lines", tag), 32'({scl_oe, sdl_oe}), 0);
                check($sformatf("%s:rst_ready", tag), 32'(cmd_ready), 1);
                check($sformatf("%s:rst_busy", tag), 32'(busy), 0);
                #1 rst = 1'b0;
                aborted    = 1'b1;
                slave_pull = 1'b0;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_at < 0) begin
                    rsp_at = c;
                    check($sformatf("%s:rsp_nack", tag), 32'(rsp_nack), 32'(exp_nack));
                    check($sformatf("%s:rsp_rdata", tag), 32'(rsp_rdata), 32'(exp_rdata));
                    check($sformatf("%s:rsp_ready", tag), 32'(cmd_ready), 1);
                    check($sformatf("%s:rsp_busy", tag), 32'(busy), 0);
                end
            end
            if (rsp_at >= 0 && c == rsp_at + 1) begin
                check($sformatf("%s:rdata_held", tag), 32'(rsp_rdata), 32'(exp_rdata));
                if (hold_valid) check($sformatf("%s:second_accepted", tag), 32'(busy), 1);
            end
        end

        cmd_valid  = 1'b0;
        slave_pull = 1'b0;
        scl_hold   = 1'b0;
        if (aborted) begin
            check($sformatf("%s:rsp_count_abort", tag), 32'(rsp_cnt), 0);
        end else begin
            check($sformatf("%s:rsp_latency", tag), 32'(rsp_at), 32'(exp_lat));
            check($sformatf("%s:rsp_count", tag), 32'(rsp_cnt), 1);
        end
        if (hold_valid) pulse_reset();
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 7'd0;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_scl_oe", 32'(scl_oe), 0);
        check("reset_sdl_oe", 32'(sdl_oe), 0);
        check("reset_ready", 32'(cmd_ready), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 0);
        check("reset_rsp_nack", 32'(rsp_nack), 0);
        rst = 1'b0;

        run_txn("wr50",    7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, -1);
        run_txn("nack22",  7'h22, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, -1);
        run_txn("rd48",    7'h48, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, -1);
        run_txn("rst_mid", 7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 52 * DIV + 2);
        run_txn("hold",    7'h11, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, -1);
        run_txn("stretch", 7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("rnd%0d", i), 7'($urandom), 1'($urandom), 8'($urandom),
                    $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), 1'b0, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
